// File: rtl/seven_seg_scan.sv
// seven_seg_scan: time-multiplexed driver for a row of common-anode
// seven-segment digits. Each digit owns one slot of SLOT clocks; the first
// BLANK_CYCLES of every slot keep all anodes off so the previous digit's
// segments never ghost onto the next one. Display data is sampled once per
// frame into shadow registers, so the visible frame is always self-consistent.
module seven_seg_scan #(
    parameter int DIGITS       = 4,
    parameter int CLK_HZ       = 100000000,
    parameter int DIGIT_HZ     = 1000,
    parameter int BLANK_CYCLES = 100
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*DIGITS-1:0]   word,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  hex_mode,
    output logic [6:0]            sseg,
    output logic [DIGITS-1:0]     an,
    output logic                  dp,
    output logic                  frame_start
);

    localparam int SLOT  = CLK_HZ / DIGIT_HZ;
    localparam int CNT_W = (SLOT > 1) ? $clog2(SLOT) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SLOT - 1);
    localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    localparam logic [6:0] SEG_OFF = 7'b1111111;

    // Reject parameter sets the scan cannot honour.
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
        $error("seven_seg_scan: DIGITS must be 1..8");
    end
    if (BLANK_CYCLES < 1 || BLANK_CYCLES > SLOT - 1) begin : g_bad_blank
        $error("seven_seg_scan: BLANK_CYCLES must be 1..SLOT-1");
    end

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [8*DIGITS-1:0] word_q;
    logic [DIGITS-1:0]   dp_q;
    logic                hex_q;

    logic                capture;
    logic                blank_phase;
    logic [7:0]          cur_byte;
    logic                cur_dp;
    logic [DIGITS-1:0]   an_next;
    logic [6:0]          glyph;

    // Hex digit glyphs, active-low {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0:    g = 7'b1000000;
            4'h1:    g = 7'b1111001;
            4'h2:    g = 7'b0100100;
            4'h3:    g = 7'b0110000;
            4'h4:    g = 7'b0011001;
            4'h5:    g = 7'b0010010;
            4'h6:    g = 7'b0000010;
            4'h7:    g = 7'b1111000;
            4'h8:    g = 7'b0000000;
            4'h9:    g = 7'b0010000;
            4'hA:    g = 7'b0001000;
            4'hB:    g = 7'b0000011;
            4'hC:    g = 7'b1000110;
            4'hD:    g = 7'b0100001;
            4'hE:    g = 7'b0000110;
            default: g = 7'b0001110;
        endcase
        return g;
    endfunction

    // ASCII glyphs: digits reuse the hex set, letters use lowercase forms,
    // anything without a sensible seven-segment shape is blank.
    function automatic logic [6:0] ascii_glyph(input logic [7:0] c);
        logic [6:0] g;
        case (c)
            8'h30, 8'h31, 8'h32, 8'h33, 8'h34,
            8'h35, 8'h36, 8'h37, 8'h38, 8'h39: g = hex_glyph(c[3:0]);
            8'h61:   g = 7'b0100000; // a
            8'h62:   g = 7'b0000011; // b
            8'h63:   g = 7'b0100111; // c
            8'h64:   g = 7'b0100001; // d
            8'h65:   g = 7'b0000110; // e
            8'h66:   g = 7'b0001110; // f
            8'h67:   g = 7'b0010000; // g
            8'h68:   g = 7'b0001011; // h
            8'h6B:   g = 7'b0001010; // k
            8'h6C:   g = 7'b1001111; // l
            8'h6D:   g = 7'b0101010; // m
            8'h6E:   g = 7'b0101011; // n
            8'h6F:   g = 7'b0100011; // o
            8'h70:   g = 7'b0001100; // p
            8'h72:   g = 7'b0101111; // r
            8'h73:   g = 7'b0010010; // s
            8'h74:   g = 7'b0000111; // t
            8'h75:   g = 7'b1100011; // u
            8'h78:   g = 7'b0001001; // x
            8'h7A:   g = 7'b0100100; // z
            default: g = SEG_OFF;
        endcase
        return g;
    endfunction

    // A frame begins on the first cycle of the leftmost digit's slot.
    assign capture     = (cnt == '0) && (idx == IDX_LAST);
    assign blank_phase = (cnt < CNT_BLANK);

    // Slot counter and digit index; the index walks left to right (high to low).
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
            idx <= IDX_LAST;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            idx <= (idx == '0) ? IDX_LAST : idx - 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow capture and frame marker, both on the frame-start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_q      <= '0;
            dp_q        <= '0;
            hex_q       <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= capture;
            if (capture) begin
                word_q <= word;
                dp_q   <= dp_in;
                hex_q  <= hex_mode;
            end
        end
    end

    // Select the active digit's shadow byte, decimal point and anode pattern.
    always_comb begin
        cur_byte = 8'h00;
        cur_dp   = 1'b0;
        an_next  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_byte   = word_q[8*i +: 8];
                cur_dp     = dp_q[i];
                an_next[i] = 1'b0;
            end
        end
        glyph = hex_q ? hex_glyph(cur_byte[3:0]) : ascii_glyph(cur_byte);
    end

    // Registered display outputs: dark during reset and the blank phase.
    always_ff @(posedge clk) begin
        if (reset || blank_phase) begin
            an   <= '1;
            sseg <= SEG_OFF;
            dp   <= 1'b1;
        end else begin
            an   <= an_next;
            sseg <= glyph;
            dp   <= ~cur_dp;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// tb_seven_seg_scan: directed bench for the seven-segment scanner with a
// 10-cycle slot, 2 blank cycles, a 4-digit instance and a 1-digit instance.
module tb_seven_seg_scan;

    localparam int BLANK = 2;
    localparam int SLOTC = 10;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [31:0] word = 32'h0;
    logic [3:0]  dp_in = 4'h0;
    logic        hex_mode = 1'b0;
    logic [6:0]  sseg;
    logic [3:0]  an;
    logic        dp;
    logic        frame_start;

    logic        r1 = 1'b1;
    logic [7:0]  word1 = 8'hF3;
    logic [0:0]  dp1_in = 1'b0;
    logic        hex1 = 1'b1;
    logic [6:0]  sseg1;
    logic [0:0]  an1;
    logic        dp1;
    logic        fs1;

    seven_seg_scan #(.DIGITS(4), .CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(BLANK)) dut (
        .clk(clk), .reset(reset), .word(word), .dp_in(dp_in), .hex_mode(hex_mode),
        .sseg(sseg), .an(an), .dp(dp), .frame_start(frame_start)
    );

    seven_seg_scan #(.DIGITS(1), .CLK_HZ(1000), .DIGIT_HZ(100), .BLANK_CYCLES(BLANK)) dut1 (
        .clk(clk), .reset(r1), .word(word1), .dp_in(dp1_in), .hex_mode(hex1),
        .sseg(sseg1), .an(an1), .dp(dp1), .frame_start(fs1)
    );

    // ---------------- scoreboard ----------------
    logic [12:0] exp_q[$];
    logic [9:0]  exp1_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    // Push expectation, advance one clock, compare on the falling edge.
    task automatic cyc(input logic [3:0] e_an, input logic [6:0] e_seg,
                       input logic e_dp, input logic e_fs, input string tag);
        logic [12:0] obs;
        logic [12:0] expv;
        exp_q.push_back({e_an, e_seg, e_dp, e_fs});
        @(posedge clk);
        @(negedge clk);
        obs  = {an, sseg, dp, frame_start};
        expv = exp_q.pop_front();
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed an/sseg/dp/fs=%b_%b_%b_%b expected %b_%b_%b_%b", tag,
                   obs[12:9], obs[8:2], obs[1], obs[0], expv[12:9], expv[8:2], expv[1], expv[0]);
        end
        n_tests++;
        assert ($countones(~an) <= 1) else begin
            n_fail++;
            $error("FAIL %s_onehot: observed an=%b expected at most one low bit", tag, an);
        end
    endtask

    task automatic cyc1(input logic e_an, input logic [6:0] e_seg,
                        input logic e_dp, input logic e_fs, input string tag);
        logic [9:0] obs;
        logic [9:0] expv;
        exp1_q.push_back({e_an, e_seg, e_dp, e_fs});
        @(posedge clk);
        @(negedge clk);
        obs  = {an1, sseg1, dp1, fs1};
        expv = exp1_q.pop_front();
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, expv);
        end
    endtask

    // Cycles c_lo..c_hi of digit d's slot (c = slot position the output reflects).
    task automatic slot_part(input int d, input logic [6:0] gl, input logic dpb,
                             input int c_lo, input int c_hi, input string tag);
        for (int c = c_lo; c <= c_hi; c++) begin
            if (c < BLANK)
                cyc(4'hF, 7'h7F, 1'b1, (d == 3 && c == 0), tag);
            else
                cyc(4'(~(4'b0001 << d)), gl, ~dpb, 1'b0, tag);
        end
    endtask

    task automatic frame(input logic [3:0][6:0] gl, input logic [3:0] dpm, input string tag);
        for (int d = 3; d >= 0; d--)
            slot_part(d, gl[d], dpm[d], 0, SLOTC - 1, tag);
    endtask

    logic [3:0][6:0] g_dead, g_hex, g_new, g_at, g_gkmr, g_9czt;

    // ---------------- directed sequence ----------------
    initial begin
        g_dead = {7'b0100001, 7'b0000110, 7'b0100000, 7'b0100001};
        g_hex  = {7'b0001110, 7'b0001000, 7'b0000000, 7'b1111001};
        g_new  = {7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001};
        g_at   = {7'b1100011, 7'b1111111, 7'b0001001, 7'b1111111};
        g_gkmr = {7'b0010000, 7'b0001010, 7'b0101010, 7'b0101111};
        g_9czt = {7'b0010000, 7'b0100111, 7'b0100100, 7'b0000111};

        word = "dead";
        hex_mode = 1'b0;
        for (int i = 0; i < 3; i++) cyc(4'hF, 7'h7F, 1'b1, 1'b0, "reset");

        // ASCII "dead", two frames to see the 40-cycle period
        reset = 1'b0;
        frame(g_dead, 4'h0, "dead_f1");
        frame(g_dead, 4'h0, "dead_f2");

        // hex mode
        hex_mode = 1'b1;
        word = 32'h0F0A0801;
        frame(g_hex, 4'h0, "hex");

        // mid-frame change is invisible; high nibbles ignored in hex mode
        slot_part(3, g_hex[3], 1'b0, 0, 9, "midchg");
        slot_part(2, g_hex[2], 1'b0, 0, 4, "midchg");
        word = 32'hA1B2C3D4;
        slot_part(2, g_hex[2], 1'b0, 5, 9, "midchg");
        slot_part(1, g_hex[1], 1'b0, 0, 9, "midchg");
        slot_part(0, g_hex[0], 1'b0, 0, 9, "midchg");
        frame(g_new, 4'h0, "newval");

        // decimal point on an undecodable character
        hex_mode = 1'b0;
        word = "u@x-";
        dp_in = 4'b0100;
        frame(g_at, 4'b0100, "dp_at");

        dp_in = 4'b0000;
        word = "gkmr";
        frame(g_gkmr, 4'h0, "gkmr");
        word = "9czt";
        frame(g_9czt, 4'h0, "9czt");

        // reset pulsed at cnt=5 of digit 1
        slot_part(3, g_9czt[3], 1'b0, 0, 9, "rst_mid");
        slot_part(2, g_9czt[2], 1'b0, 0, 9, "rst_mid");
        slot_part(1, g_9czt[1], 1'b0, 0, 4, "rst_mid");
        reset = 1'b1;
        cyc(4'hF, 7'h7F, 1'b1, 1'b0, "rst_blank");
        reset = 1'b0;
        frame(g_9czt, 4'h0, "rst_resume");

        // single-digit instance
        for (int i = 0; i < 2; i++) cyc1(1'b1, 7'h7F, 1'b1, 1'b0, "d1_reset");
        r1 = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < SLOTC; c++) begin
                if (c < BLANK) cyc1(1'b1, 7'h7F, 1'b1, (c == 0), "d1_blank");
                else           cyc1(1'b0, 7'b0110000, 1'b1, 1'b0, "d1_show");
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Hard stop if the sequence ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/seven_seg_scan.md
SEVEN_SEG_SCAN -- requirements
Module: seven_seg_scan

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of multiplexed digits; legal range 1..8.
REQ-002 SHALL have parameter CLK_HZ, default 100000000, input clock frequency in Hz.
REQ-003 SHALL have parameter DIGIT_HZ, default 1000, per-digit slot rate; SLOT = CLK_HZ/DIGIT_HZ cycles.
REQ-004 SHALL have parameter BLANK_CYCLES, default 100, dead time at the start of each slot; legal range 1..SLOT-1.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on posedge clk.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port word  input  8*DIGITS  display data; byte d = word[8d+7:8d] drives digit d; digit DIGITS-1 is leftmost.
REQ-008 SHALL have port dp_in  input  DIGITS  per-digit decimal point request, 1 = lit.
REQ-009 SHALL have port hex_mode  input  1  1 = byte low nibble decoded as hex; 0 = byte decoded as ASCII.
REQ-010 SHALL have port sseg  output  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
REQ-011 SHALL have port an  output  DIGITS  digit enables, active-low; at most one bit low at any time.
REQ-012 SHALL have port dp  output  1  decimal point, active-low.
REQ-013 SHALL have port frame_start  output  1  one-cycle pulse marking input capture.

Function
REQ-014 SHALL keep a slot counter cnt, 0..SLOT-1, incrementing every cycle and wrapping to 0.
REQ-015 SHALL keep a digit index idx; on cnt wrap, idx decrements, and goes from 0 to DIGITS-1 (scan order left to right).
REQ-016 SHALL assert frame_start, registered, for exactly the one cycle following each cycle with cnt==0 and idx==DIGITS-1 and reset low.
REQ-017 SHALL capture word, dp_in and hex_mode into shadow registers on that same edge; the display uses shadow values only; input changes mid-frame are invisible until the next capture.
REQ-018 SHALL drive registered outputs, one cycle latency: for cnt < BLANK_CYCLES, drive an all ones, sseg 7'b1111111, dp 1 (BLANK phase).
REQ-019 SHALL, for cnt >= BLANK_CYCLES (SHOW phase), drive an[idx]=0 and all other bits 1, sseg = glyph(shadow byte idx), and dp = ~shadow_dp[idx].
REQ-020 SHALL use the hex glyph set 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-021 SHALL, in ASCII mode, decode '0'-'9' as hex 0-9 and 'a'-'f' as lowercase forms a=0100000, b=0000011, c=0100111, d=0100001, e=0000110, f=0001110.
REQ-022 SHALL, in ASCII mode, also decode g=0010000, h=0001011, k=0001010, l=1001111, m=0101010, n=0101011, o=0100011, p=0001100, r=0101111, s=0010010, t=0000111, u=1100011, x=0001001, z=0100100.
REQ-023 SHALL drive all other ASCII codes as blank (1111111) while still honouring dp.
REQ-024 SHALL ignore byte bits [7:4] in hex mode.
REQ-025 SHALL, with DIGITS=1, keep idx at 0 and assert frame_start once per slot.
REQ-026 SHALL make the 1 -> 0 edge of any an bit occur at least BLANK_CYCLES cycles after the 0 -> 1 edge of the previous digit.

Reset
REQ-027 SHALL, while reset is high, set cnt=0, idx=DIGITS-1, shadows=0, an all ones, sseg 7'b1111111, dp 1 and frame_start 0.
REQ-028 SHALL, on the first edge with reset low, capture inputs and assert frame_start in the cycle after; reset asserted mid-slot SHALL blank the outputs from the next cycle on and restart the scan at digit DIGITS-1.

Verification (CLK_HZ=1000, DIGIT_HZ=100 -> SLOT=10; BLANK_CYCLES=2; DIGITS=4)
REQ-029 SHALL check: reset, then word="dead", hex_mode=0 -> frame_start at cycle 1 after release; per slot 2 blank cycles then 8 show cycles; an 0111 with sseg 0100001, then 1011 with 0000110, then 1101 with 0100000, then 1110 with 0100001; frame period 40 cycles.
REQ-030 SHALL check: hex_mode=1, word=32'h0F0A0801 -> digits show 0001110, 0001000, 0000000, 1111001 left to right.
REQ-031 SHALL check: word changed during digit 2 slot -> remaining digits of the frame unchanged; new value appears only after the next frame_start.
REQ-032 SHALL check: dp_in=4'b0100, byte 2 = "@" -> digit 2 shows sseg 1111111 with dp 0; dp 1 on all other digits and in all BLANK phases.
REQ-033 SHALL check: reset pulsed at cnt=5 of digit 1 -> blank outputs in the next cycle; scan resumes at an 0111 after the 2 blank cycles; at most one an bit low at every cycle.
REQ-034 SHALL check: DIGITS=1, hex_mode=1, byte 8'hF3 -> an toggles 1/0 each slot, sseg 0110000, frame_start every 10 cycles.
